// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared state encoding and truth-table constants for the gate sweep sequencer
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int VEC_W = 2;

  // Truth tables indexed by {in1,in2}
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR  = 4'b1110;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - 4-bit load/decrement settle counter with zero flag
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - on-chip exhaustive sweep and check of a two-input/two-output logic gate
// Optional GATE_SWEEP_CAPTURE_EN adds the capture[7:0] raw-sample output.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXP_OUT1      = TT_AND,
  parameter logic [3:0] EXP_OUT2      = TT_OR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_in1,
  output logic       gate_in2,
  input  logic       gate_out1,
  input  logic       gate_out2,
`ifdef GATE_SWEEP_CAPTURE_EN
  output logic [7:0] capture,
`endif
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("gate_sweep_ctrl: SETTLE_CYCLES must be within 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state, state_next;
  logic [VEC_W-1:0] vec;
  logic             timer_zero;
  logic             timer_load;
  logic             accept;
  logic             clear_results;
  logic             sample_now;
  logic             mismatch;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .zero     (timer_zero)
  );

  assign mismatch = (gate_out1 != EXP_OUT1[vec]) || (gate_out2 != EXP_OUT2[vec]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A restart straight from DONE publishes the finished result for one cycle,
  // so its clear is deferred to the first SETTLE cycle (no SAMPLE can collide).
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    timer_load    = 1'b0;
    sample_now    = 1'b0;
    clear_results = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept        = 1'b1;
          timer_load    = 1'b1;
          clear_results = 1'b1;
          state_next    = SETTLE;
        end
      end
      SETTLE: begin
        clear_results = done;
        if (timer_zero) state_next = SAMPLE;
      end
      SAMPLE: begin
        sample_now = 1'b1;
        if (vec == 2'd3) begin
          state_next = DONE;
        end else begin
          timer_load = 1'b1;
          state_next = SETTLE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          state_next = SETTLE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      gate_in1  <= 1'b0;
      gate_in2  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
    end else begin
      if (accept) begin
        vec      <= '0;
        gate_in1 <= 1'b0;
        gate_in2 <= 1'b0;
        busy     <= 1'b1;
      end
      if (clear_results) begin
        err_count <= 3'd0;
        done      <= 1'b0;
        pass      <= 1'b0;
      end
      if (sample_now) begin
        if (mismatch) err_count <= err_count + 3'd1;
        if (vec == 2'd3) begin
          busy <= 1'b0;
        end else begin
          vec                  <= vec + 2'd1;
          {gate_in1, gate_in2} <= vec + 2'd1;
        end
      end
      if (state == DONE) begin
        done     <= 1'b1;
        pass     <= (err_count == 3'd0);
        vec      <= '0;
        gate_in1 <= 1'b0;
        gate_in2 <= 1'b0;
      end
    end
  end

`ifdef GATE_SWEEP_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || clear_results) begin
      capture <= 8'd0;
    end else if (sample_now) begin
      capture[{vec, 1'b0} +: 2] <= {gate_out1, gate_out2};
    end
  end
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - self-checking bench for gate_sweep_ctrl with a behavioural gate and sweep model
module tb_gate_sweep_ctrl;

  localparam logic [3:0] REF_AND = 4'b1000;
  localparam logic [3:0] REF_OR  = 4'b1110;
  localparam logic [3:0] REF_NOR = 4'b0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic       gi1_0, gi2_0, gi1_1, gi2_1;
  logic       go1_0, go2_0, go1_1, go2_1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [7:0] cap0, cap1;
  logic [3:0] tt1, tt2;

  logic       sel;
  logic       o_busy, o_done, o_pass;
  logic [2:0] o_err;
  logic [1:0] o_gin;
  logic [7:0] o_cap;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the logic_gate block under test
  assign go1_0 = tt1[{gi1_0, gi2_0}];
  assign go2_0 = tt2[{gi1_0, gi2_0}];
  assign go1_1 = tt1[{gi1_1, gi2_1}];
  assign go2_1 = tt2[{gi1_1, gi2_1}];

  gate_sweep_ctrl u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start0),
    .gate_in1  (gi1_0),
    .gate_in2  (gi2_0),
    .gate_out1 (go1_0),
    .gate_out2 (go2_0),
`ifdef GATE_SWEEP_CAPTURE_EN
    .capture   (cap0),
`endif
    .busy      (busy0),
    .done      (done0),
    .pass      (pass0),
    .err_count (err0)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .gate_in1  (gi1_1),
    .gate_in2  (gi2_1),
    .gate_out1 (go1_1),
    .gate_out2 (go2_1),
`ifdef GATE_SWEEP_CAPTURE_EN
    .capture   (cap1),
`endif
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .err_count (err1)
  );

`ifndef GATE_SWEEP_CAPTURE_EN
  assign cap0 = 8'd0;
  assign cap1 = 8'd0;
`endif

  always_comb begin
    o_busy = sel ? busy1 : busy0;
    o_done = sel ? done1 : done0;
    o_pass = sel ? pass1 : pass0;
    o_err  = sel ? err1  : err0;
    o_gin  = sel ? {gi1_1, gi2_1} : {gi1_0, gi2_0};
    o_cap  = sel ? cap1  : cap0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic s, input logic v);
    if (s) start1 = v;
    else   start0 = v;
  endtask

  function automatic int ref_errs(input logic [3:0] m1, input logic [3:0] m2);
    int n = 0;
    for (int v = 0; v < 4; v++)
      if (m1[v] !== REF_AND[v] || m2[v] !== REF_OR[v]) n++;
    return n;
  endfunction

  function automatic logic [7:0] ref_capture(input logic [3:0] m1, input logic [3:0] m2);
    logic [7:0] r = 8'd0;
    for (int v = 0; v < 4; v++) begin
      r[2*v+1] = m1[v];
      r[2*v]   = m2[v];
    end
    return r;
  endfunction

  // One full sweep from IDLE. Cycle c counts from the first cycle after the
  // accept edge; the vector is c/(S+1), busy spans 4*(S+1) cycles, and done
  // appears one cycle after that.
  task automatic do_sweep(input logic s_sel, input logic [3:0] m1, input logic [3:0] m2,
                          input logic hold, input int poke);
    int         s, len, e;
    logic [7:0] ecap;
    s    = s_sel ? 1 : 2;
    len  = 4 * (s + 1);
    e    = ref_errs(m1, m2);
    ecap = ref_capture(m1, m2);
    sel  = s_sel;
    tt1  = m1;
    tt2  = m2;
    drive_start(s_sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) drive_start(s_sel, 1'b0);
    for (int c = 0; c < len; c++) begin
      check("busy_run", 32'(o_busy), 32'd1);
      check("done_run", 32'(o_done), 32'd0);
      check("gate_in", 32'(o_gin), c / (s + 1));
      if (c == poke) drive_start(s_sel, 1'b1);
      else if (!hold && c == poke + 1) drive_start(s_sel, 1'b0);
      @(negedge clk);
    end
    check("busy_end", 32'(o_busy), 32'd0);
    check("done_gap", 32'(o_done), 32'd0);
    @(negedge clk);
    check("done", 32'(o_done), 32'd1);
    check("err_count", 32'(o_err), 32'(e));
    check("pass", 32'(o_pass), 32'(e == 0));
    check("busy_after", 32'(o_busy), 32'(hold));
    check("gate_in_idle", 32'(o_gin), 32'd0);
`ifdef GATE_SWEEP_CAPTURE_EN
    check("capture", 32'(o_cap), 32'(ecap));
`endif
    if (hold) begin
      drive_start(s_sel, 1'b0);
      @(negedge clk);
      check("restart_done_clr", 32'(o_done), 32'd0);
      check("restart_err_clr", 32'(o_err), 32'd0);
      check("restart_busy", 32'(o_busy), 32'd1);
      repeat (len) @(negedge clk);
      check("restart_done", 32'(o_done), 32'd1);
      check("restart_err", 32'(o_err), 32'(e));
    end
  endtask

  initial begin
    logic [3:0] r1, r2;
    sel    = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    tt1    = REF_AND;
    tt2    = REF_OR;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_pass", 32'(o_pass), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      check("rst_gate_in", 32'(o_gin), 32'd0);
      check("rst_capture", 32'(o_cap), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Ideal gate, out1 stuck-at-0, NOR on out2 with a start pulse mid-sweep
    do_sweep(1'b0, REF_AND, REF_OR, 1'b0, -1);
    do_sweep(1'b0, 4'b0000, REF_OR, 1'b0, -1);
    do_sweep(1'b0, REF_AND, REF_NOR, 1'b0, 5);

    // Reset while vector 2 is settling, then a clean sweep
    sel = 1'b0;
    tt1 = REF_AND;
    tt2 = REF_NOR;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_gate_in", 32'(o_gin), 32'd2);
    check("mid_err", 32'(o_err), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_err", 32'(o_err), 32'd0);
    check("abort_gate_in", 32'(o_gin), 32'd0);
    @(negedge clk);
    do_sweep(1'b0, REF_AND, REF_OR, 1'b0, -1);

    // Short settle with start held high: done pulse then immediate restart
    @(negedge clk);
    do_sweep(1'b1, REF_AND, REF_OR, 1'b1, -1);
    @(negedge clk);
    @(negedge clk);

    // Random gate behaviour on both instances
    for (int k = 0; k < 8; k++) begin
      r1 = 4'($urandom_range(0, 15));
      r2 = 4'($urandom_range(0, 15));
      if (k == 0) begin
        r1 = REF_AND;
        r2 = REF_OR;
      end
      do_sweep(k[0], r1, r2, 1'b0, int'($urandom_range(0, 5)));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Hardware sequencer for the two-input / two-output `logic_gate` block.
- Steps the gate through all four input vectors `{in1,in2}` = 00, 01, 10, 11, waits a settle interval, then samples both outputs.
- Compares each sample against parameterised truth tables and counts mismatches.
- Replaces bench-driven stimulus with an on-chip self-test that the board top can trigger from a button and report on LEDs.

Parameters:
- SETTLE_CYCLES, 2, clock cycles the vector is held before sampling; legal range 1..15.
- EXP_OUT1, 4'b1000, expected out1 truth table; bit index = {in1,in2} (default is AND).
- EXP_OUT2, 4'b1110, expected out2 truth table; bit index = {in1,in2} (default is OR).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE or DONE
- gate_in1  output  1  drives logic_gate in1 (MSB of vector)
- gate_in2  output  1  drives logic_gate in2 (LSB of vector)
- gate_out1  input  1  logic_gate out1
- gate_out2  input  1  logic_gate out2
- busy  output  1  high from the cycle after start is accepted until sweep ends
- done  output  1  high after a sweep completes; cleared by the next accepted start or by rst
- pass  output  1  valid while done=1; 1 iff err_count==0
- err_count  output  3  number of mismatching vectors, 0..4

Behaviour:
- Reset (rst=1 at clock edge, any state): state=IDLE; gate_in1=gate_in2=busy=done=pass=0; err_count=0; timer and vector counter=0.
  - Reset mid-sweep aborts immediately; no partial result is retained.
- States:
  - IDLE: waits for start. On start=1: vec<=0, timer<=SETTLE_CYCLES-1, err_count<=0, done<=0, pass<=0, go to SETTLE.
  - SETTLE: gate_in = vec (registered outputs). busy=1. Timer decrements each cycle. Timer==0 → SAMPLE.
  - SAMPLE: one cycle. mismatch = (gate_out1 != EXP_OUT1[vec]) | (gate_out2 != EXP_OUT2[vec]).
    - err_count increments by 1 per mismatching vector; saturation is not needed since the maximum is 4.
    - If vec==3 → DONE.
    - Else vec<=vec+1, timer<=SETTLE_CYCLES-1, → SETTLE.
  - DONE: one cycle. busy<=0, done<=1, pass<=(final err_count==0), gate_in<=00.
    - If start=1 in this cycle, restart exactly as from IDLE. Otherwise → IDLE.
- Latency: start accepted at edge N; done=1 visible after edge N+4*(SETTLE_CYCLES+1)+1. With the default, done rises 13 edges after start.
- gate_in holds the same vector for SETTLE_CYCLES+1 cycles, including the SAMPLE cycle. The vector never changes during SAMPLE.
- start while busy=1 is ignored. No queuing.
- Vector counter is 2 bits; no wrap occurs because DONE is taken at vec==3.
- SETTLE_CYCLES outside 1..15: elaboration error via a generate-time check.

Optional Feature:
- Macro: GATE_SWEEP_CAPTURE_EN.
- With the macro defined:
  - Adds output `capture[7:0]`.
  - In SAMPLE, capture[2*vec+1 : 2*vec] <= {gate_out1, gate_out2}.
  - Cleared on rst and on an accepted start; held stable after DONE.
- Without the macro: port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package/header `gate_sweep_pkg`:
  - State encoding constants: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3.
  - Vector width constant (2).
  - Default truth-table constants for AND/OR.
- One natural sub-module: `settle_timer`.
  - 4-bit load/decrement counter with `load`, `load_val` and `zero` flag.
  - Instantiated once; the FSM, compare and counters stay in gate_sweep_ctrl.

Test Plan:
1. Default params; ideal AND/OR model on gate_out; pulse start → busy for 12 cycles, then done=1, pass=1, err_count=0. gate_in sequence is 00,01,10,11, each held 3 cycles.
2. out1 stuck-at-0 model; start → done=1, pass=0, err_count=3'd1 (only vector 11 fails).
3. out2 inverted (NOR instead of OR); start → err_count=3'd4, pass=0. Pulse start during busy → no restart, done timing unchanged.
4. Assert rst while vec==2 in SETTLE → next edge busy=0, done=0, err_count=0, gate_in=00. A new start then completes a full 12-cycle sweep with pass=1.
5. SETTLE_CYCLES=1; start held high continuously → done pulse after 8 busy cycles; immediate restart from DONE with done cleared on the following edge.
6. GATE_SWEEP_CAPTURE_EN defined, ideal model → capture=8'b11_01_01_00 at done. Without the macro, the same run passes test 1 checks.
